// File: rtl/uart_tx_arbiter_if.sv
// Bundle of producer-side handshake and transmitter-side signals for uart_tx_arbiter.
// The arbiter uses the slave modport; producers/transmitter environment uses master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [NUM_REQ-1:0]   timeout;
  logic                 busy;
  logic [ID_W-1:0]      active_id;
  logic                 tx_newd;
  logic [7:0]           tx_data;
  logic                 tx_done;

  modport master (
    output req, req_data, tx_done,
    input  gnt, done, timeout, busy, active_id, tx_newd, tx_data
  );

  modport slave (
    input  req, req_data, tx_done,
    output gnt, done, timeout, busy, active_id, tx_newd, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog (timeout pulses).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NEWD_HOLD   = 110,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (NEWD_HOLD > 1) ? $clog2(NEWD_HOLD) : 1;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;
  logic                tx_newd_q, tx_newd_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                tx_done_q;
  logic                tx_done_rise;
  logic [7:0]          req_byte [NUM_REQ];
  logic                sel_found;
  logic [ID_W-1:0]     sel_id;
`ifdef UART_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0]  timeout_q, timeout_d;
  logic [31:0]         wait_cnt_q, wait_cnt_d;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
    assign req_byte[gi] = bus.req_data[8*gi +: 8];
  end

  assign tx_done_rise = bus.tx_done & ~tx_done_q;

  // First pending request searching upward from the previous owner, wrapping.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_q) + 1 + k) % NUM_REQ;
      if (!sel_found && bus.req[ID_W'(idx)]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    done_d      = '0;
    tx_newd_d   = tx_newd_q;
    tx_data_d   = tx_data_q;
    active_id_d = active_id_q;
    last_d      = last_q;
    hold_d      = hold_q;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_d   = '0;
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = LAUNCH;
          gnt_d       = NUM_REQ'(1) << sel_id;
          tx_newd_d   = 1'b1;
          tx_data_d   = req_byte[sel_id];
          active_id_d = sel_id;
          hold_d      = HOLD_W'(NEWD_HOLD - 1);
        end
      end
      LAUNCH: begin
        // Counter loaded with NEWD_HOLD-1 so tx_newd spans exactly NEWD_HOLD cycles.
        if (hold_q == '0) begin
          tx_newd_d = 1'b0;
          state_d   = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 32'd1;
`endif
        if (tx_done_rise) begin
          state_d = RELEASE;
          done_d  = NUM_REQ'(1) << active_id_q;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wait_cnt_d == 32'(TIMEOUT_CYC)) begin
          timeout_d = NUM_REQ'(1) << active_id_q;
          last_d    = active_id_q;
          state_d   = IDLE;
        end
`endif
      end
      RELEASE: begin
        last_d  = active_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      tx_newd_q   <= 1'b0;
      tx_data_q   <= '0;
      active_id_q <= '0;
      last_q      <= LAST_RST;
      hold_q      <= '0;
      tx_done_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q   <= '0;
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tx_newd_q   <= tx_newd_d;
      tx_data_q   <= tx_data_d;
      active_id_q <= active_id_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      tx_done_q   <= bus.tx_done;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q   <= timeout_d;
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_id_q;
  assign bus.tx_newd   = tx_newd_q;
  assign bus.tx_data   = tx_data_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  // Watchdog not built; keep the parameter referenced for a uniform interface.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(32'(TIMEOUT_CYC));
  assign bus.timeout        = '0;
`endif
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
- Grants one requester at a time and latches its byte.
- Launches the transmitter with a stretched newd pulse, so the slower baud-derived clock samples it.
- Waits for the transmitter's done edge, then returns a per-requester completion pulse.
- Sits between producer logic and the UART transmitter inside the UART top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
NEWD_HOLD, 110, clk cycles tx_newd is held high; must be ≥ one baud-clock period and < one frame time.
TIMEOUT_CYC, 20000, clk cycles allowed in WAIT_DONE before abort (used only with the optional feature).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
req  in  NUM_REQ  per-requester request; hold high with data stable until gnt.
req_data  in  8*NUM_REQ  byte i at bits [8i+7:8i].
gnt  out  NUM_REQ  one-hot 1-cycle pulse: byte accepted.
done  out  NUM_REQ  one-hot 1-cycle pulse: byte fully transmitted.
timeout  out  NUM_REQ  one-hot 1-cycle pulse: transmission aborted.
busy  out  1  high whenever state != IDLE.
active_id  out  $clog2(NUM_REQ)  index of the current owner.
tx_newd  out  1  start request to the transmitter.
tx_data  out  8  byte to the transmitter, stable while busy.
tx_done  in  1  transmitter done flag, synchronous to the same clk source.

Behaviour:
- Reset (rst high at a clk edge), all registered:
  - state=IDLE.
  - gnt, done, timeout, tx_newd, busy = 0.
  - tx_data=0, active_id=0.
  - last pointer=NUM_REQ-1, so req[0] has first priority.
  - hold counter=0, tx_done_q=0.
- States are IDLE, LAUNCH, WAIT_DONE and RELEASE.
- IDLE:
  - If any req bit is high, select the first high bit searching from last+1, wrapping modulo NUM_REQ.
  - Register tx_data=req_data[sel], active_id=sel and load the hold counter; go to LAUNCH.
  - If no req bit is high, stay in IDLE.
- LAUNCH:
  - gnt[active_id] is high for the first LAUNCH cycle only.
  - tx_newd is high for exactly NEWD_HOLD cycles.
  - When the hold counter expires, drop tx_newd and go to WAIT_DONE.
- WAIT_DONE:
  - Wait for a rising edge of tx_done, detected as tx_done & ~tx_done_q with tx_done_q registered every cycle.
  - A level already high on entry does not count; it must fall and rise again.
  - On the edge, go to RELEASE.
- RELEASE (one cycle):
  - done[active_id]=1, last=active_id; go to IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle 0 → gnt and tx_newd high at cycle 1.
  - Minimum arbitration gap is 1 IDLE cycle between owners.
- req is sampled only in IDLE.
  - A req still high after its gnt is treated as a new request at the next IDLE.
  - Round-robin fairness: a continuously requesting source cannot win twice while another source is pending.
- req_data is captured once; later changes are ignored.
- Output exclusivity: gnt, done and timeout are never simultaneously asserted, and at most one bit of each vector is high.
- Reset mid-operation:
  - Abort immediately and drop tx_newd on the same edge.
  - No done or timeout pulse is issued.
- If the transmitter never returns done, the arbiter stays in WAIT_DONE indefinitely unless the optional feature is enabled.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A 32-bit counter runs from 0 during WAIT_DONE.
  - On reaching TIMEOUT_CYC without a tx_done edge, pulse timeout[active_id] for one cycle, set last=active_id and go to IDLE. done is not pulsed.
  - The counter clears on every WAIT_DONE entry.
  - A tx_done edge arriving in the same cycle as expiry takes priority: done is pulsed, timeout is not.
- Undefined:
  - No counter is built and the timeout port is tied to 0.

Test Plan:
1. Single request: req=4'b0010, byte 0xA5 → gnt[1] at cycle 1; tx_newd high 110 cycles; tx_data=0xA5; after the tx_done rise, done[1] for 1 cycle; busy returns to 0.
2. All request: req=4'b1111 held, bytes 0x11/0x22/0x33/0x44 → grant order 0,1,2,3,0; tx_data matches each owner; each done precedes the next gnt.
3. Fairness: req[0] held continuously, req[2] raised during owner 0's WAIT_DONE → next grant goes to 2 before 0 again.
4. Stale done: tx_done already high entering WAIT_DONE → no done until tx_done falls and rises again.
5. Reset mid-op: rst asserted 50 cycles into LAUNCH → next cycle tx_newd=0, busy=0, no done; after release, req[0] is granted first.
6. With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=200, tx_done held 0 → timeout[owner] pulses exactly 200 cycles after WAIT_DONE entry and the arbiter returns to IDLE; without the macro, the timeout port stays 0.
